// File: rtl/tri_pkg.sv
// Shared constants and types for the triangle LUT / multiply datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tri_pkg;

    localparam int LUT_AW    = 10;
    localparam int LUT_DW    = 16;
    localparam int COEF_W    = 14;
    localparam int PROD_W    = LUT_DW + COEF_W;
    localparam int LUT_DEPTH = 512;
    // Ramp slope: each index step adds 2^LUT_SHIFT to the table value.
    localparam int LUT_SHIFT = 6;

    localparam logic [COEF_W-1:0]        COEF_ONE = 14'h2000;
    localparam logic signed [LUT_DW-1:0] LUT_SAT  = 16'sd32767;

    typedef logic signed [LUT_DW-1:0] lut_t;
    typedef logic        [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Table values are never negative, so this negation cannot overflow.
    function automatic lut_t lut_negate(input lut_t value, input logic neg);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/tri_quarter_rom.sv
// Quarter-wave triangle table: linear ramp for idx<512, saturated above.
// Latency: 0 (purely combinational).
// Backpressure: none.
module tri_quarter_rom
    import tri_pkg::*;
(
    input  logic [LUT_AW-1:0] i_index,
    output lut_t              o_value
);

    // Ramp region is idx*64; anything at or beyond the table depth saturates.
    always_comb begin
        o_value = LUT_SAT;
        if (i_index < LUT_AW'(LUT_DEPTH)) begin
            o_value = lut_t'({1'b0, i_index[LUT_AW-2:0], {LUT_SHIFT{1'b0}}});
        end
    end

endmodule

// File: rtl/tri_lut_mult.sv
// Triangle LUT lookup, optional negation, then signed x unsigned weight multiply.
// Latency: 2 clocks i_valid->o_valid (3 with TRI_LUT_MULT_PIPE_EN defined).
// Backpressure: none; fully pipelined, one sample per clock, data zeroed when invalid.
module tri_lut_mult
    import tri_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [LUT_AW-1:0] i_index,
    input  logic              i_negate,
    input  coef_t             i_coef,
    output lut_t              o_lut,
    output logic              o_valid,
    output prod_t             o_product
);

    lut_t  w_rom_val;
    prod_t w_prod;

    logic  r_s1_vld;
    lut_t  r_lut_s;
    coef_t r_coef_s;

    logic  r_s2_vld;
    prod_t r_prod_s2;

    tri_quarter_rom u_rom (
        .i_index (i_index),
        .o_value (w_rom_val)
    );

    // Stage 1: register the signed table value and the weight; zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_lut_s  <= '0;
            r_coef_s <= '0;
        end else begin
            r_s1_vld <= i_valid;
            r_lut_s  <= i_valid ? lut_negate(w_rom_val, i_negate) : '0;
            r_coef_s <= i_valid ? i_coef : '0;
        end
    end

    // Weight is unsigned, so it is zero-extended before the signed multiply;
    // the full-width product cannot overflow (|32767*16383| < 2^29).
    assign w_prod = prod_t'(r_lut_s) * prod_t'($signed({1'b0, r_coef_s}));

    // Stage 2: register the product alongside its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_prod_s2 <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_prod_s2 <= r_s1_vld ? w_prod : '0;
        end
    end

    assign o_lut = r_lut_s;

`ifdef TRI_LUT_MULT_PIPE_EN
    logic  r_s3_vld;
    prod_t r_prod_s3;

    // Stage 3: extra retiming register after the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_vld  <= 1'b0;
            r_prod_s3 <= '0;
        end else begin
            r_s3_vld  <= r_s2_vld;
            r_prod_s3 <= r_s2_vld ? r_prod_s2 : '0;
        end
    end

    assign o_valid   = r_s3_vld;
    assign o_product = r_prod_s3;
`else
    assign o_valid   = r_s2_vld;
    assign o_product = r_prod_s2;
`endif

endmodule

// File: tb/tb_tri_lut_mult.sv
// Scoreboard bench for tri_lut_mult: driver pushes expected products, monitor pops on o_valid.
// Latency: expects 2 clocks (3 with TRI_LUT_MULT_PIPE_EN defined).
// Backpressure: none; stimulus streams freely.
module tb_tri_lut_mult;
    import tri_pkg::*;

`ifdef TRI_LUT_MULT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic [LUT_AW-1:0] i_index;
    logic              i_negate;
    coef_t             i_coef;
    lut_t              o_lut;
    logic              o_valid;
    prod_t             o_product;

    tri_lut_mult dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_index   (i_index),
        .i_negate  (i_negate),
        .i_coef    (i_coef),
        .o_lut     (o_lut),
        .o_valid   (o_valid),
        .o_product (o_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint prod;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    int     cyc     = 0;
    int     n_chk   = 0;
    int     n_pass  = 0;
    bit     mon_en  = 1'b0;
    longint exp_lut = 0;

    // Reference: ramp of 64 per index step below 512, saturated at 32767 above.
    function automatic longint ref_lut(input int idx, input bit neg);
        longint v;
        v = (idx < 512) ? longint'(idx) * 64 : 32767;
        return neg ? -v : v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // o_lut model: one clock after the input, zero when idle or in reset.
    always @(posedge clk)
        exp_lut <= rst ? 0 : (i_valid ? ref_lut(int'(i_index), i_negate) : 0);

    // Monitor: compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("o_lut", longint'(o_lut), exp_lut);
            if (o_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_valid: o_valid=1 with no sample outstanding (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("o_product", longint'(o_product), e.prod);
                    check("latency", longint'(cyc - e.cyc), longint'(LAT));
                end
            end else begin
                check("idle_product_zero", longint'(o_product), 0);
            end
        end
    end

    task automatic send(input bit v, input int idx, input bit neg, input int coef);
        @(posedge clk);
        #1;
        i_valid  = v;
        i_index  = LUT_AW'(idx);
        i_negate = neg;
        i_coef   = COEF_W'(coef);
        if (v) q.push_back('{prod: ref_lut(idx, neg) * longint'(coef), cyc: cyc});
    endtask

    // Reset for n clocks with i_valid held high; samples that would emerge
    // after reset takes effect are dropped from the expectation queue.
    task automatic reset_pulse(input int n);
        exp_t keep[$];
        @(posedge clk);
        #1;
        rst      = 1'b1;
        i_valid  = 1'b1;
        i_index  = LUT_AW'($urandom_range(0, 1023));
        i_negate = 1'($urandom_range(0, 1));
        i_coef   = COEF_W'($urandom_range(0, 16383));
        foreach (q[k]) if (q[k].cyc + LAT <= cyc) keep.push_back(q[k]);
        q = keep;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            i_index = LUT_AW'($urandom_range(0, 1023));
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic random_burst(input int n);
        for (int k = 0; k < n; k++) begin
            int coef;
            coef = ($urandom_range(0, 7) == 0) ? 16383 : int'($urandom_range(0, 16383));
            send($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), coef);
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b1;
        i_index  = 10'd5;
        i_negate = 1'b0;
        i_coef   = COEF_ONE;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);

        // Directed points.
        send(1, 0,    0, 'h2000);
        send(1, 1,    0, 'h2000);
        send(1, 511,  1, 'h1000);
        send(1, 512,  0, 1);
        send(1, 1023, 0, 1);
        send(1, 511,  0, 16383);
        send(1, 1023, 1, 16383);
        send(0, 0, 0, 0);

        random_burst(200);

        // Reset with samples still in flight, then idle to catch stray valids.
        send(1, 100, 0, 'h2000);
        send(1, 200, 1, 'h1234);
        reset_pulse(2);
        repeat (LAT + 3) send(0, 0, 0, 0);

        random_burst(100);

        repeat (LAT + 4) send(0, 0, 0, 0);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d samples never emerged, expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
